// File: rtl/tb_mem_multiport.sv
// tb_mem_multiport: round-robin multi-port RAM with fixed-latency in-order responses
module tb_mem_multiport #(
  parameter int          NumPorts    = 2,
  parameter int          DataWidth   = 64,
  parameter logic [63:0] DramBase    = 64'h8000_0000,
  parameter int          MemAddrBits = 16,
  parameter int          Latency     = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumPorts-1:0]             req_i,
  input  logic [NumPorts*64-1:0]          addr_i,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts*DataWidth/8-1:0] be_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  output logic [NumPorts-1:0]             gnt_o,
  output logic [NumPorts-1:0]             rvalid_o,
  output logic [NumPorts*DataWidth-1:0]   rdata_o,
  output logic [NumPorts-1:0]             err_o
);
  localparam int Bytes = DataWidth / 8;
  localparam int OffBits = $clog2(Bytes);
  localparam int PW = NumPorts > 1 ? $clog2(NumPorts) : 1;
  localparam logic [63:0] MemBytes = 64'(Bytes) << MemAddrBits;
  logic [DataWidth-1:0] mem [2**MemAddrBits];
  logic [PW-1:0] last_q, sel;
  logic any, hit, we;
  logic [63:0] addr, off;
  logic [Bytes-1:0] be;
  logic [DataWidth-1:0] wdata, rd;
  logic [MemAddrBits-1:0] idx;
  logic pv [Latency];
  logic [PW-1:0] pp [Latency];
  logic [DataWidth-1:0] pd [Latency];
  logic pe [Latency];
  always_comb begin
    any = 1'b0;
    sel = '0;
    gnt_o = '0;
    for (int i = 1; i <= NumPorts; i++) begin
      if (!any && req_i[PW'((int'(last_q) + i) % NumPorts)]) begin
        any = 1'b1;
        sel = PW'((int'(last_q) + i) % NumPorts);
      end
    end
    gnt_o[sel] = any;
  end
  always_comb begin
    addr = addr_i[64*sel +: 64];
    we = we_i[sel];
    be = be_i[Bytes*sel +: Bytes];
    wdata = wdata_i[DataWidth*sel +: DataWidth];
    off = addr - DramBase;
    hit = addr >= DramBase && off < MemBytes;
    idx = MemAddrBits'(off >> OffBits);
    rd = (we || !hit) ? '0 : mem[idx];
  end
  always_ff @(posedge clk_i) begin
    if (rst_ni && any && we && hit)
      for (int b = 0; b < Bytes; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PW'(NumPorts - 1);
      for (int k = 0; k < Latency; k++) begin
        pv[k] <= 1'b0;
        pp[k] <= '0;
        pd[k] <= '0;
        pe[k] <= 1'b0;
      end
    end else begin
      if (any) last_q <= sel;
      pv[0] <= any;
      pp[0] <= sel;
      pd[0] <= any ? rd : '0;
      pe[0] <= any && !hit;
      for (int k = 1; k < Latency; k++) begin
        pv[k] <= pv[k-1];
        pp[k] <= pp[k-1];
        pd[k] <= pd[k-1];
        pe[k] <= pe[k-1];
      end
    end
  end
  always_comb begin
    rvalid_o = '0;
    rdata_o = '0;
    err_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (pv[Latency-1] && pp[Latency-1] == PW'(p)) begin
        rvalid_o[p] = 1'b1;
        rdata_o[DataWidth*p +: DataWidth] = pd[Latency-1];
        err_o[p] = pe[Latency-1];
      end
    end
  end
endmodule

// File: tb/tb_tb_mem_multiport.sv
// tb_tb_mem_multiport: randomized scoreboard bench for tb_mem_multiport (2 ports, latency 4, 256 words)
module tb_tb_mem_multiport;
  localparam int NP = 2;
  localparam int L = 4;
  localparam int MAB = 8;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SPAN = 64'd8 << MAB;
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } tx_t;
  typedef struct {
    int          port;
    logic [63:0] data;
    logic        err;
    int          due;
  } exp_t;
  logic clk, rst_n;
  logic [NP-1:0] req, we, gnt, rvalid, err;
  logic [NP*64-1:0] addr, wdata, rdata;
  logic [NP*8-1:0] be;
  tx_t txq [NP][$];
  exp_t sbq [$];
  logic [63:0] mdl [2**MAB];
  logic [NP-1:0] busy;
  int wait_n [NP];
  int cyc = 0, checks = 0, errors = 0, acc_cnt = 0, rr_last = NP - 1;
  logic watch_first = 1'b0;

  tb_mem_multiport #(.NumPorts(NP), .DataWidth(64), .DramBase(BASE), .MemAddrBits(MAB), .Latency(L)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask
  task automatic push(input int p, input logic w, input logic [63:0] a, input logic [7:0] b, input logic [63:0] d);
    tx_t t;
    t.we = w; t.addr = a; t.be = b; t.wdata = d;
    txq[p].push_back(t);
  endtask
  task automatic drain();
    int n = 0;
    while ((txq[0].size() != 0 || txq[1].size() != 0 || busy != '0 || sbq.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) fail("drain_timeout");
  endtask

  // Driver and reference model: issues held requests, predicts the grant and the response.
  initial begin
    tx_t t;
    exp_t e;
    int g, c, wi;
    logic [63:0] a, ed;
    logic h;
    req = '0; we = '0; addr = '0; be = '0; wdata = '0; busy = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (!busy[p]) begin
          if (txq[p].size() != 0) begin
            t = txq[p].pop_front();
            busy[p] = 1'b1; wait_n[p] = 0; req[p] = 1'b1; we[p] = t.we;
            addr[p*64 +: 64] = t.addr; be[p*8 +: 8] = t.be; wdata[p*64 +: 64] = t.wdata;
          end else req[p] = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst_n) rr_last = NP - 1;
      else begin
        g = -1;
        for (int i = 1; i <= NP; i++) begin
          c = (rr_last + i) % NP;
          if (req[c] && g < 0) g = c;
        end
        chk("gnt", 64'(gnt), g < 0 ? 64'd0 : 64'd1 << g);
        if (g >= 0) begin
          a = addr[g*64 +: 64];
          h = a >= BASE && a < BASE + SPAN;
          ed = '0;
          if (h) begin
            wi = int'((a - BASE) >> 3);
            if (we[g]) begin
              for (int b = 0; b < 8; b++)
                if (be[g*8 + b]) mdl[wi][8*b +: 8] = wdata[g*64 + 8*b +: 8];
            end else ed = mdl[wi];
          end
          e.port = g; e.data = ed; e.err = !h; e.due = cyc + L;
          sbq.push_back(e);
          if (watch_first) begin
            chk("first_grant_after_reset", 64'(g), 64'd0);
            watch_first = 1'b0;
          end
          rr_last = g;
          busy[g] = 1'b0;
          acc_cnt++;
        end
        for (int p = 0; p < NP; p++) begin
          if (busy[p]) begin
            wait_n[p]++;
            if (wait_n[p] > 200) begin
              fail($sformatf("grant_timeout port %0d", p));
              busy[p] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Monitor: pops expectations in grant order as responses appear.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_rdata", rdata[63:0] | rdata[127:64], 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        sbq.delete();
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (rvalid[p]) begin
            if (sbq.size() == 0) fail($sformatf("unexpected_rvalid port %0d", p));
            else begin
              e = sbq.pop_front();
              chk("resp_port", 64'(p), 64'(e.port));
              chk("resp_rdata", rdata[p*64 +: 64], e.data);
              chk("resp_err", 64'(err[p]), 64'(e.err));
              chk("resp_cycle", 64'(cyc), 64'(e.due));
            end
          end else begin
            chk("idle_rdata", rdata[p*64 +: 64], 64'd0);
            chk("idle_err", 64'(err[p]), 64'd0);
          end
        end
        if (sbq.size() != 0 && sbq[0].due < cyc) begin
          e = sbq.pop_front();
          fail($sformatf("missing_rvalid port %0d due %0d", e.port, e.due));
        end
      end
    end
  end

  initial begin
    int a0, n, p;
    logic [63:0] a;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int w = 0; w < 2**MAB; w++)
      push(w % NP, 1'b1, BASE + 64'(w) * 8, 8'hFF, {$urandom, $urandom});
    drain();
    push(0, 1'b1, 64'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788);
    push(0, 1'b0, 64'h8000_0008, 8'h00, 64'd0);
    push(0, 1'b1, 64'h8000_0008, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
    push(0, 1'b0, 64'h8000_0008, 8'h00, 64'd0);
    drain();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, BASE + 64'(8 * i), 8'h00, 64'd0);
      push(1, 1'b0, BASE + 64'(8 * (i + 10)), 8'h00, 64'd0);
    end
    drain();
    push(0, 1'b0, 64'h0000_1000, 8'h00, 64'd0);
    push(1, 1'b0, BASE + SPAN, 8'h00, 64'd0);
    push(0, 1'b1, BASE + SPAN, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
    push(1, 1'b1, BASE - 8, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE);
    push(0, 1'b0, BASE, 8'h00, 64'd0);
    push(1, 1'b0, BASE + SPAN - 8, 8'h00, 64'd0);
    drain();
    for (int i = 0; i < 4; i++) push(0, 1'b0, BASE + 64'(8 * (20 + 3 * i)), 8'h00, 64'd0);
    drain();
    for (int i = 0; i < 300; i++) begin
      p = int'($urandom_range(0, NP - 1));
      case ($urandom_range(0, 9))
        0: a = 64'h0000_1000 + 64'($urandom_range(0, 255));
        1: a = BASE + SPAN + 64'($urandom_range(0, 4095));
        default: a = BASE + 64'($urandom_range(0, 2**MAB - 1)) * 8 + 64'($urandom_range(0, 7));
      endcase
      push(p, 1'($urandom_range(0, 1)), a, 8'($urandom), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end
    drain();
    a0 = acc_cnt;
    for (int i = 0; i < 3; i++) push(0, 1'b0, BASE + 64'(8 * (40 + i)), 8'h00, 64'd0);
    n = 0;
    while (acc_cnt < a0 + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) fail("inflight_setup_timeout");
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (L + 3) @(posedge clk);
    watch_first = 1'b1;
    push(0, 1'b0, 64'h8000_0008, 8'h00, 64'd0);
    push(1, 1'b0, BASE + 64'h10, 8'h00, 64'd0);
    drain();
    repeat (L + 2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tb_mem_multiport.md
TB_MEM_MULTIPORT -- requirements
Module: tb_mem_multiport

Interface
REQ-001 Parameter NumPorts, default 2, number of requester ports (1..8).
REQ-002 Parameter DataWidth, default 64, word width in bits (multiple of 8, >=32).
REQ-003 Parameter DramBase, default 64'h80000000, byte address of first RAM word.
REQ-004 Parameter MemAddrBits, default 16, log2 of RAM depth in words.
REQ-005 Parameter Latency, default 1, cycles from grant to response (1..8).
REQ-006 clk_i  in  1  single clock, all logic rising-edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 req_i  in  NumPorts  per-port request.
REQ-009 addr_i  in  NumPorts x 64  per-port byte address.
REQ-010 we_i  in  NumPorts  per-port write enable.
REQ-011 be_i  in  NumPorts x DataWidth/8  per-port byte enables.
REQ-012 wdata_i  in  NumPorts x DataWidth  per-port write data.
REQ-013 gnt_o  out  NumPorts  per-port grant, combinational from req_i and arbiter state.
REQ-014 rvalid_o  out  NumPorts  per-port response valid.
REQ-015 rdata_o  out  NumPorts x DataWidth  per-port read data, valid with rvalid_o.
REQ-016 err_o  out  NumPorts  per-port error flag, valid with rvalid_o.

Function
REQ-017 At most one gnt_o bit SHALL be high per cycle, and only for a port with req_i high.
REQ-018 Arbitration SHALL be round-robin: search starts at port (last_granted+1) mod NumPorts; last_granted updates only on a grant.
REQ-019 A request SHALL be accepted in the cycle req_i & gnt_o; requester holds addr/we/be/wdata stable until granted.
REQ-020 Word index SHALL be (addr - DramBase) >> log2(DataWidth/8); low address bits ignored.
REQ-021 Hit condition: DramBase <= addr < DramBase + 2**MemAddrBits * DataWidth/8, unsigned 64-bit compare.
REQ-022 Granted write, hit: RAM bytes with be set SHALL update at end of grant cycle; other bytes unchanged.
REQ-023 Granted read, hit: data SHALL be sampled from RAM in grant cycle (writes from earlier cycles visible).
REQ-024 Miss (read or write): RAM unchanged, response rdata all-zero, err 1.
REQ-025 Every accepted request (read or write) SHALL produce exactly one rvalid_o pulse on its own port exactly Latency cycles after grant cycle.
REQ-026 Write responses SHALL carry rdata all-zero, err 0 on hit.
REQ-027 Response pipeline SHALL be Latency stages deep (valid, port id, data, err); it SHALL accept a new request every cycle without stalling.
REQ-028 Responses SHALL return in grant order; rvalid_o has no backpressure.
REQ-029 rdata_o and err_o SHALL be zero on a port whenever its rvalid_o is low.
REQ-030 When Latency=1 and NumPorts=1 with gnt tied high externally, behaviour SHALL equal a single-port RAM returning rvalid one cycle after req.

Reset
REQ-031 While rst_ni low: rvalid_o=0, rdata_o=0, err_o=0, all pipeline valid bits 0, last_granted=NumPorts-1 (port 0 wins first).
REQ-032 gnt_o MAY assert during reset but no request SHALL be accepted while rst_ni low.
REQ-033 Reset asserted mid-operation SHALL drop all in-flight responses; none SHALL appear after release.
REQ-034 RAM contents SHALL NOT be cleared by reset (preloadable by bench via hierarchical access).

Verification
REQ-035 Port 0 write addr 0x80000008, be 0xFF, data 0x1122334455667788; then read same -> rvalid after Latency cycles, rdata 0x1122334455667788, err 0.
REQ-036 Partial write be 0x0F, data 0xAAAAAAAABBBBBBBB over word 0x1122334455667788 -> readback 0x11223344BBBBBBBB.
REQ-037 Both ports request continuously 6 cycles (NumPorts=2) -> grants alternate 0,1,0,1,0,1; responses in same order, each Latency cycles later.
REQ-038 Read addr 0x00001000 (below DramBase) and 0x80000000 + 2**MemAddrBits*8 -> rvalid, rdata 0, err 1; RAM unchanged.
REQ-039 Latency=4, back-to-back reads of 4 different words -> 4 consecutive rvalid cycles starting 4 cycles after first grant, correct data each.
REQ-040 Assert rst_ni low with 3 reads in flight (Latency=4) -> no rvalid after release; next request granted to port 0.
